// File: rtl/count_seq_ctrl.sv
// Sequencing controller for small up/down counters: loads a start value, steps to a
// terminal value, repeats for a programmed number of passes, with pause/resume and abort.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; Y and pass_cnt hold their last values
// LOAD  | one cycle: Y <= start value, pass_cnt <= 0
// RUN   | stepping Y toward the end value, one step per edge
// HOLD  | paused; start resumes from frozen Y, stop aborts to IDLE
// DONE  | one-cycle done pulse, then back to IDLE
module count_seq_ctrl #(
    parameter int WIDTH  = 4,
    parameter int PASS_W = 4
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              start,
    input  logic              stop,
    input  logic              dir,
    input  logic [WIDTH-1:0]  limit,
    input  logic [PASS_W-1:0] passes,
    output logic [WIDTH-1:0]  Y,
    output logic [PASS_W-1:0] pass_cnt,
    output logic              busy,
    output logic              tc,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        HOLD = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [WIDTH-1:0]    y_nx;
    logic [PASS_W-1:0]   pass_cnt_nx;
    logic                dir_q;
    logic                dir_nx;
    logic [WIDTH-1:0]    limit_q;
    logic [WIDTH-1:0]    limit_nx;
    logic [PASS_W-1:0]   passes_q;
    logic [PASS_W-1:0]   passes_nx;
    logic [WIDTH-1:0]    start_val;
    logic [WIDTH-1:0]    end_val;
    logic [PASS_W:0]     pass_next;

    assign start_val = dir_q ? '0 : limit_q;
    assign end_val   = dir_q ? limit_q : '0;
    // One bit wider so the pass compare cannot overflow at the top of the range.
    assign pass_next = {1'b0, pass_cnt} + (PASS_W+1)'(1);

    assign busy = (state == LOAD) || (state == RUN) || (state == HOLD);
    assign tc   = (state == RUN) && (Y == end_val);
    assign done = (state == DONE);

    always_ff @(posedge clock) begin
        if (clear) begin
            state    <= IDLE;
            Y        <= '0;
            pass_cnt <= '0;
            dir_q    <= 1'b1;
            limit_q  <= '0;
            passes_q <= '0;
        end else begin
            state    <= state_nx;
            Y        <= y_nx;
            pass_cnt <= pass_cnt_nx;
            dir_q    <= dir_nx;
            limit_q  <= limit_nx;
            passes_q <= passes_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        y_nx        = Y;
        pass_cnt_nx = pass_cnt;
        dir_nx      = dir_q;
        limit_nx    = limit_q;
        passes_nx   = passes_q;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    dir_nx    = dir;
                    limit_nx  = limit;
                    passes_nx = passes;
                    if (passes == '0) begin
                        // Zero completed passes out of zero requested.
                        pass_cnt_nx = '0;
                        state_nx    = DONE;
                    end else begin
                        state_nx = LOAD;
                    end
                end
            end
            LOAD: begin
                y_nx        = start_val;
                pass_cnt_nx = '0;
                state_nx    = RUN;
            end
            RUN: begin
                if (stop) begin
                    state_nx = HOLD;
                end else if (Y != end_val) begin
                    y_nx = dir_q ? (Y + WIDTH'(1)) : (Y - WIDTH'(1));
                end else if (pass_next < {1'b0, passes_q}) begin
                    y_nx        = start_val;
                    pass_cnt_nx = pass_next[PASS_W-1:0];
                end else begin
                    pass_cnt_nx = passes_q;
                    state_nx    = DONE;
                end
            end
            HOLD: begin
                if (stop) begin
                    state_nx = IDLE;
                end else if (start) begin
                    state_nx = RUN;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Directed bench for count_seq_ctrl: expected per-cycle outputs are queued as stimulus
// is driven and compared one cycle later, after the DUT has taken the edge.
module tb_count_seq_ctrl;

    logic       clock;
    logic       clear;
    logic       start;
    logic       stop;
    logic       dir;
    logic [3:0] limit;
    logic [3:0] passes;
    logic [3:0] Y;
    logic [3:0] pass_cnt;
    logic       busy;
    logic       tc;
    logic       done;

    count_seq_ctrl #(.WIDTH(4), .PASS_W(4)) dut (
        .clock    (clock),
        .clear    (clear),
        .start    (start),
        .stop     (stop),
        .dir      (dir),
        .limit    (limit),
        .passes   (passes),
        .Y        (Y),
        .pass_cnt (pass_cnt),
        .busy     (busy),
        .tc       (tc),
        .done     (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0] y;
        logic [3:0] pc;
        logic       busy;
        logic       tc;
        logic       done;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int start_cyc = 0;
    int busy_cnt  = 0;
    int m_y       = 0;
    int m_pc      = 0;
    int m_i       = 0;
    int r_dir     = 0;
    int r_lim     = 0;
    int r_pas     = 0;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic push(input string tag, input int y, input int pc,
                        input logic b, input logic t, input logic d);
        exp_t e;
        e.y    = 4'(y);
        e.pc   = 4'(pc);
        e.busy = b;
        e.tc   = t;
        e.done = d;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        m_y  = y;
        m_pc = pc;
    endtask

    task automatic tick();
        exp_t  e;
        string tg;
        @(posedge clock);
        #1;
        cyc++;
        if (busy === 1'b1) busy_cnt++;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            tg = tag_q.pop_front();
            check_val({tg, "_y"},    16'(Y),        16'(e.y));
            check_val({tg, "_pc"},   16'(pass_cnt), 16'(e.pc));
            check_val({tg, "_busy"}, 16'(busy),     16'(e.busy));
            check_val({tg, "_tc"},   16'(tc),       16'(e.tc));
            check_val({tg, "_done"}, 16'(done),     16'(e.done));
        end
    endtask

    // Start edge: DUT enters LOAD with Y and pass_cnt still holding their old values.
    task automatic start_run(input int d, input int l, input int p);
        r_dir    = d;
        r_lim    = l;
        r_pas    = p;
        m_i      = 0;
        dir      = 1'(d);
        limit    = 4'(l);
        passes   = 4'(p);
        start    = 1'b1;
        stop     = 1'b0;
        busy_cnt = 0;
        push("load", m_y, m_pc, 1'b1, 1'b0, 1'b0);
        tick();
        start_cyc = cyc;
        start     = 1'b0;
    endtask

    // Expected RUN cycle m_i of the whole run: offset within the pass picks Y.
    task automatic step_run(input string tag);
        int off;
        int y;
        off = m_i % (r_lim + 1);
        y   = (r_dir != 0) ? off : (r_lim - off);
        push(tag, y, m_i / (r_lim + 1), 1'b1, (off == r_lim), 1'b0);
        tick();
        m_i++;
    endtask

    task automatic finish_run(input int extra);
        int lat;
        lat = r_pas * (r_lim + 1) + 1 + extra;
        push("done", (r_dir != 0) ? r_lim : 0, r_pas, 1'b0, 1'b0, 1'b1);
        tick();
        check_val("latency", 16'(cyc - start_cyc), 16'(lat));
        check_val("busy_cycles", 16'(busy_cnt), 16'(lat));
        push("idle_after", m_y, m_pc, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic run_normal(input int d, input int l, input int p, input bit scramble);
        start_run(d, l, p);
        for (int i = 0; i < p * (l + 1); i++) begin
            if (scramble) begin
                limit  = 4'($urandom_range(0, 15));
                dir    = 1'($urandom_range(0, 1));
                passes = 4'($urandom_range(0, 15));
            end
            step_run("run");
        end
        finish_run(0);
    endtask

    initial begin
        clear  = 1'b1;
        start  = 1'b0;
        stop   = 1'b0;
        dir    = 1'b1;
        limit  = 4'd0;
        passes = 4'd0;

        push("reset", 0, 0, 1'b0, 1'b0, 1'b0);
        tick();
        push("reset", 0, 0, 1'b0, 1'b0, 1'b0);
        tick();
        clear = 1'b0;

        // Up run: 0,1,2,3,0,1,2,3 then done, Y stays 3.
        run_normal(1, 3, 2, 1'b0);

        // start and stop together in IDLE: nothing happens.
        start = 1'b1;
        stop  = 1'b1;
        push("start_stop_idle", m_y, m_pc, 1'b0, 1'b0, 1'b0);
        tick();
        push("start_stop_idle", m_y, m_pc, 1'b0, 1'b0, 1'b0);
        tick();
        start = 1'b0;
        stop  = 1'b0;

        // Down run 9..0 with limit/dir/passes inputs changing mid-run.
        run_normal(0, 9, 1, 1'b1);

        // Clear held two cycles mid-run at Y=5.
        start_run(1, 7, 2);
        repeat (6) step_run("pre_clear");
        clear = 1'b1;
        push("clear_mid", 0, 0, 1'b0, 1'b0, 1'b0);
        tick();
        push("clear_mid", 0, 0, 1'b0, 1'b0, 1'b0);
        tick();
        clear = 1'b0;
        push("after_clear", 0, 0, 1'b0, 1'b0, 1'b0);
        tick();

        // Pause at Y=4 for three HOLD cycles, then resume.
        start_run(1, 7, 1);
        repeat (5) step_run("pause_pre");
        stop = 1'b1;
        push("hold", 4, 0, 1'b1, 1'b0, 1'b0);
        tick();
        stop = 1'b0;
        push("hold", 4, 0, 1'b1, 1'b0, 1'b0);
        tick();
        push("hold", 4, 0, 1'b1, 1'b0, 1'b0);
        tick();
        start = 1'b1;
        push("resume", 4, 0, 1'b1, 1'b0, 1'b0);
        tick();
        start = 1'b0;
        repeat (3) step_run("pause_post");
        finish_run(4);

        // Abort: stop, stop -> IDLE with Y=3, pass_cnt=0, no done.
        start_run(0, 5, 2);
        repeat (3) step_run("abort_pre");
        stop = 1'b1;
        push("abort_hold", 3, 0, 1'b1, 1'b0, 1'b0);
        tick();
        push("abort_idle", 3, 0, 1'b0, 1'b0, 1'b0);
        tick();
        stop = 1'b0;
        push("abort_idle2", 3, 0, 1'b0, 1'b0, 1'b0);
        tick();

        // passes=0: done straight after the start edge, Y unchanged.
        dir    = 1'b1;
        limit  = 4'd9;
        passes = 4'd0;
        start  = 1'b1;
        push("zero_pass", 3, 0, 1'b0, 1'b0, 1'b1);
        tick();
        start = 1'b0;
        push("zero_pass_idle", 3, 0, 1'b0, 1'b0, 1'b0);
        tick();

        // limit=0: three one-cycle passes, tc high every RUN cycle.
        run_normal(1, 0, 3, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
